// File: rtl/uart_rx_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_pkg
// Shared definitions for the UART receiver slice.
//   - PRESCALE_DEF / EDGE_W_DEF : default oversample ratio and matching edge
//                                 counter width
//   - BIT_W_DEF                 : bit counter width (bit indices 0..15)
//   - Frame indices             : bit_cnt values of the start, last data,
//                                 parity and stop bits
//   - maj3(a,b,c)               : 2-of-3 majority function
// -----------------------------------------------------------------------------
package uart_rx_pkg;

    localparam int PRESCALE_DEF = 8;
    localparam int EDGE_W_DEF   = $clog2(PRESCALE_DEF);
    localparam int BIT_W_DEF    = 4;

    // bit_cnt value of each field within a frame
    localparam int START_IDX      = 0;
    localparam int DATA_LAST_IDX  = 8;
    localparam int PAR_IDX        = 9;
    localparam int STOP_IDX_NOPAR = 9;
    localparam int STOP_IDX_PAR   = 10;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/rx_majority_vote.sv
// -----------------------------------------------------------------------------
// rx_majority_vote
// Three vote registers and the voted-bit register for one received bit.
// Ports:
//   clk          in   oversample clock
//   ARSTn        in   asynchronous active-low reset
//   cap          in   [2:0] capture strobes for votes s0, s1, s2 (one-hot in
//                     time, issued by the parent's edge counter)
//   rx_in        in   serial line, already synchronized to clk
//   sampled_bit  out  registered majority of the three votes
//   samp_valid   out  1-cycle pulse on the edge sampled_bit is updated
// -----------------------------------------------------------------------------
module rx_majority_vote
    import uart_rx_pkg::*;
(
    input  logic       clk,
    input  logic       ARSTn,
    input  logic [2:0] cap,
    input  logic       rx_in,
    output logic       sampled_bit,
    output logic       samp_valid
);

    logic [2:0] vote_reg;
    logic       vote_live;
    logic       sampled_bit_reg;
    logic       samp_valid_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_vote
            always_ff @(posedge clk or negedge ARSTn) begin
                if (!ARSTn) begin
                    vote_reg[gi] <= 1'b1;
                end else if (cap[gi]) begin
                    vote_reg[gi] <= rx_in;
                end
            end
        end
    endgenerate

    // The third vote is taken straight from the line on its own capture edge,
    // so the result is ready one cycle earlier than waiting for s2 to settle.
    assign vote_live = cap[2] ? rx_in : vote_reg[2];

    always_ff @(posedge clk or negedge ARSTn) begin
        if (!ARSTn) begin
            sampled_bit_reg <= 1'b1;
            samp_valid_reg  <= 1'b0;
        end else begin
            samp_valid_reg <= cap[2];
            if (cap[2]) begin
                sampled_bit_reg <= maj3(vote_reg[0], vote_reg[1], vote_live);
            end
        end
    end

    assign sampled_bit = sampled_bit_reg;
    assign samp_valid  = samp_valid_reg;

endmodule

// File: rtl/rx_edge_bit_sampler.sv
// -----------------------------------------------------------------------------
// rx_edge_bit_sampler
// Oversampling timebase and mid-bit majority sampler for the UART receiver.
// Ports:
//   clk          in   oversample clock
//   ARSTn        in   asynchronous active-low reset
//   enable       in   count enable from RX FSM; low clears both counters
//   dat_samp_en  in   sampling enable from RX FSM
//   RX_IN        in   serial line, already synchronized to clk
//   edge_cnt     out  oversample edge index within the current bit
//   bit_cnt      out  bit index within the frame (0 = start), saturates at max
//   sampled_bit  out  majority-voted value of the current bit
//   samp_valid   out  1-cycle pulse when sampled_bit is updated
// -----------------------------------------------------------------------------
module rx_edge_bit_sampler
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE = PRESCALE_DEF,
    parameter int EDGE_W   = EDGE_W_DEF,
    parameter int BIT_W    = BIT_W_DEF
) (
    input  logic              clk,
    input  logic              ARSTn,
    input  logic              enable,
    input  logic              dat_samp_en,
    input  logic              RX_IN,
    output logic [EDGE_W-1:0] edge_cnt,
    output logic [BIT_W-1:0]  bit_cnt,
    output logic              sampled_bit,
    output logic              samp_valid
);

    localparam int                MID       = PRESCALE / 2;
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(PRESCALE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = {BIT_W{1'b1}};

    logic [EDGE_W-1:0] edge_cnt_reg, edge_cnt_next;
    logic [BIT_W-1:0]  bit_cnt_reg,  bit_cnt_next;
    logic [2:0]        cap;

    always_comb begin
        edge_cnt_next = edge_cnt_reg;
        bit_cnt_next  = bit_cnt_reg;
        if (!enable) begin
            edge_cnt_next = '0;
            bit_cnt_next  = '0;
        end else if (edge_cnt_reg == EDGE_LAST) begin
            edge_cnt_next = '0;
            // Saturate so a stuck-high enable never aliases back to the start bit
            if (bit_cnt_reg != BIT_LAST) begin
                bit_cnt_next = bit_cnt_reg + BIT_W'(1);
            end
        end else begin
            edge_cnt_next = edge_cnt_reg + EDGE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge ARSTn) begin
        if (!ARSTn) begin
            edge_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
        end else begin
            edge_cnt_reg <= edge_cnt_next;
            bit_cnt_reg  <= bit_cnt_next;
        end
    end

    // Capture strobes at MID-1, MID, MID+1. Gated by enable so a bit aborted
    // by enable falling never completes a vote on the clearing edge.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cap
            assign cap[gi] = enable && dat_samp_en &&
                             (edge_cnt_reg == EDGE_W'(MID - 1 + gi));
        end
    endgenerate

    rx_majority_vote u_vote (
        .clk         (clk),
        .ARSTn       (ARSTn),
        .cap         (cap),
        .rx_in       (RX_IN),
        .sampled_bit (sampled_bit),
        .samp_valid  (samp_valid)
    );

    assign edge_cnt = edge_cnt_reg;
    assign bit_cnt  = bit_cnt_reg;

endmodule
